// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the signals between the two requesters, the arbiter and the
// synchronous data memory.
//   Requester side : reqN, weN, lockN, addrN, wdataN (N = 0 datapath LD/ST,
//                    N = 1 debug/loader) in; gntN, rvalidN, rdata out.
//   Memory side    : mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in.
//   Status         : busy out.
// Modports:
//   slave  - the arbiter's view (requests and mem_rdata in, grants and
//            memory strobes out).
//   master - the environment's view (requesters plus memory).
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              we0;
   logic              lock0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;

   logic              req1;
   logic              we1;
   logic              lock1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;

   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  req0, we0, lock0, addr0, wdata0,
      input  req1, we1, lock1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output req0, we0, lock0, addr0, wdata0,
      output req1, we1, lock1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single-port synchronous data memory.
// Requester 0 is the datapath load/store unit, requester 1 the debug/loader.
// An ownership starts in IDLE (round-robin on a tie), issues one beat per
// GRANT cycle, spends one RESP cycle on reads, and may continue for up to
// MAX_BURST beats while the owner keeps lock and req asserted.
//
// Parameters: ADDR_W (word address width), DATA_W (data width),
//             MAX_BURST (beats per locked ownership, 2..15).
// Ports:
//   clk  - clock, all state changes on its rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: requester handshakes, read return path,
//          memory strobes and busy flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   logic [1:0]        state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_owner_reg, last_owner_next;
   logic [3:0]        beat_count_reg, beat_count_next;
   logic [DATA_W-1:0] rdata_hold_reg;

   logic              own_req;
   logic              own_we;
   logic              own_lock;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;
   logic              burst_ok;
   logic              winner;
   logic              in_grant;
   logic              in_resp;
   logic [3:0]        beat_inc;

   // Current owner's request fields, muxed straight from the inputs
   assign own_req   = owner_reg ? bus.req1   : bus.req0;
   assign own_we    = owner_reg ? bus.we1    : bus.we0;
   assign own_lock  = owner_reg ? bus.lock1  : bus.lock0;
   assign own_addr  = owner_reg ? bus.addr1  : bus.addr0;
   assign own_wdata = owner_reg ? bus.wdata1 : bus.wdata0;

   // Owner may take another beat only while it still asks for it and the
   // ownership has not used up its beat allowance.
   assign burst_ok = own_lock & own_req & (beat_count_reg < BURST_LIMIT);

   // Saturating beat counter increment
   assign beat_inc = (beat_count_reg == 4'hF) ? beat_count_reg : beat_count_reg + 4'd1;

   // Lone requester wins; on a tie the one that did not own last time wins
   assign winner = (bus.req0 & bus.req1) ? ~last_owner_reg : bus.req1;

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      beat_count_next = beat_count_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               owner_next      = winner;
               last_owner_next = winner;
               beat_count_next = 4'd1;
               state_next      = GRANT;
            end
         end
         GRANT: begin
            if (!own_we) begin
               state_next = RESP;
            end else if (burst_ok) begin
               beat_count_next = beat_inc;
               state_next      = GRANT;
            end else begin
               state_next = IDLE;
            end
         end
         RESP: begin
            // A dropped req here fails burst_ok, so the burst ends
            if (burst_ok) begin
               beat_count_next = beat_inc;
               state_next      = GRANT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;
         beat_count_reg <= 4'd0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         beat_count_reg <= beat_count_next;
      end
   end

   // The memory registers the read word at the end of GRANT, so mem_rdata is
   // already a registered value during RESP. It is passed through in RESP and
   // captured here so rdata keeps the last result afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_hold_reg <= '0;
      end else if (state_reg == RESP) begin
         rdata_hold_reg <= bus.mem_rdata;
      end
   end

   assign in_grant = (state_reg == GRANT);
   assign in_resp  = (state_reg == RESP);

   // Outputs decode from state, so an asynchronous reset clears them at once
   assign bus.gnt0      = in_grant & ~owner_reg;
   assign bus.gnt1      = in_grant &  owner_reg;
   assign bus.rvalid0   = in_resp  & ~owner_reg;
   assign bus.rvalid1   = in_resp  &  owner_reg;
   assign bus.mem_en    = in_grant;
   assign bus.mem_we    = in_grant & own_we;
   assign bus.mem_addr  = in_grant ? own_addr  : '0;
   assign bus.mem_wdata = in_grant ? own_wdata : '0;
   assign bus.rdata     = in_resp  ? bus.mem_rdata : rdata_hold_reg;
   assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by random two-port traffic. Stimulus pushes each
// issued transaction into a per-port queue; the monitor pops on every grant and
// checks the memory strobes, predicts read data from a reference memory array,
// and checks the matching rvalid one cycle later. Exclusivity and the waiting
// bound are checked every cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MB = 4;

   typedef struct packed {
      logic          we;
      logic          lock;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      logic          known;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vec_cnt = 0;
   int   miscompares = 0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memory: read data appears the cycle after mem_en
   logic [DW-1:0] mem_arr [0:255];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem_arr[bus.mem_addr[7:0]];
      end
   end

   // Reference model state
   txn_t          exp_q0[$];
   txn_t          exp_q1[$];
   rsp_t          rsp_q0[$];
   rsp_t          rsp_q1[$];
   logic [DW-1:0] ref_mem [0:255];
   bit            ref_known [0:255];
   bit            rd_due0, rd_due1;
   int            wait0, wait1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int p, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txn_t t;
      t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
      if (p == 0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.lock0 = lock; bus.addr0 = addr; bus.wdata0 = wdata;
         exp_q0.push_back(t);
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.lock1 = lock; bus.addr1 = addr; bus.wdata1 = wdata;
         exp_q1.push_back(t);
      end
   endtask

   task automatic idle(input int p);
      if (p == 0) begin bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; end
      else        begin bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_ctrl"}, 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                bus.mem_en, bus.mem_we, bus.busy}), 32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      chk({tag, "_rdata"},     32'(bus.rdata),     32'd0);
   endtask

   // Per-port scoreboard step, called once per cycle at the falling edge
   task automatic mon_port(input int p, input logic g, input logic rv,
                           input logic rq, input logic og);
      txn_t t;
      rsp_t r;
      bit   due;
      int   wc;
      due = (p == 0) ? rd_due0 : rd_due1;
      wc  = (p == 0) ? wait0 : wait1;
      if (rv || due) begin
         chk($sformatf("rvalid%0d_timing", p), 32'(rv), 32'(due));
         if (rv && due) begin
            if (p == 0) r = rsp_q0.pop_front(); else r = rsp_q1.pop_front();
            if (r.known) chk($sformatf("rdata%0d", p), 32'(bus.rdata), 32'(r.data));
            $display("txn p%0d RD data=%h (expected %h, known=%0d)", p, bus.rdata, r.data, r.known);
         end
      end
      due = 1'b0;
      if (g) begin
         chk($sformatf("gnt%0d_with_req", p), 32'(rq), 32'd1);
         if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            chk($sformatf("gnt%0d_unexpected", p), 32'd1, 32'd0);
         end else begin
            if (p == 0) t = exp_q0.pop_front(); else t = exp_q1.pop_front();
            chk($sformatf("mem_we_p%0d", p),   32'(bus.mem_we),   32'(t.we));
            chk($sformatf("mem_addr_p%0d", p), 32'(bus.mem_addr), 32'(t.addr));
            if (t.we) begin
               chk($sformatf("mem_wdata_p%0d", p), 32'(bus.mem_wdata), 32'(t.wdata));
               ref_mem[t.addr[7:0]]   = t.wdata;
               ref_known[t.addr[7:0]] = 1'b1;
               $display("txn p%0d WR addr=%h data=%h lock=%0d", p, t.addr, t.wdata, t.lock);
            end else begin
               r.known = ref_known[t.addr[7:0]];
               r.data  = ref_mem[t.addr[7:0]];
               if (p == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
               due = 1'b1;
            end
         end
         wc = 0;
      end else if (rq && og) begin
         wc++;
         chk($sformatf("wait_bound_p%0d", p), 32'(wc <= MB), 32'd1);
      end else if (!rq) begin
         wc = 0;
      end
      if (p == 0) begin rd_due0 = due; wait0 = wc; end
      else        begin rd_due1 = due; wait1 = wc; end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_due0 = 1'b0; rd_due1 = 1'b0;
            rsp_q0.delete(); rsp_q1.delete();
            wait0 = 0; wait1 = 0;
         end else begin
            chk("single_gnt",    32'(bus.gnt0 & bus.gnt1),       32'd0);
            chk("single_rvalid", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
            chk("mem_en_is_gnt", 32'(bus.mem_en), 32'(bus.gnt0 | bus.gnt1));
            mon_port(0, bus.gnt0, bus.rvalid0, bus.req0, bus.gnt1);
            mon_port(1, bus.gnt1, bus.rvalid1, bus.req1, bus.gnt0);
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      int   gp;
      int   n0;
      int   order [0:6];
      bit   idle_chk;
      bit   found;
      bit   act  [0:1];
      bit   forc [0:1];
      logic g    [0:1];
      bit   stopping;
      logic nwe, nlock;

      order = '{0, 0, 0, 0, 1, 0, 0};
      bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      rd_due0 = 0; rd_due1 = 0; wait0 = 0; wait1 = 0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check_quiet("reset");
      step();
      rst = 1'b0;

      // Single write from port 0
      step();
      issue(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
      @(negedge clk);
      chk("wr_c0_gnt0", 32'(bus.gnt0), 32'd0);
      step();
      @(negedge clk);
      chk("wr_c1_gnt0",      32'(bus.gnt0),      32'd1);
      chk("wr_c1_mem_en",    32'(bus.mem_en),    32'd1);
      chk("wr_c1_mem_we",    32'(bus.mem_we),    32'd1);
      chk("wr_c1_mem_addr",  32'(bus.mem_addr),  32'h0010);
      chk("wr_c1_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
      step();
      idle(0);
      @(negedge clk);
      chk("wr_c2_busy", 32'(bus.busy), 32'd0);

      // Single read from port 1 of the word just written
      step();
      issue(1, 1'b0, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("rd_c0_gnt1", 32'(bus.gnt1), 32'd0);
      step();
      @(negedge clk);
      chk("rd_c1_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
      step();
      idle(1);
      @(negedge clk);
      chk("rd_c2_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'b01);
      chk("rd_c2_rdata",  32'(bus.rdata), 32'hBEEF);
      step();
      @(negedge clk);
      chk("rd_c3_rvalid1", 32'(bus.rvalid1), 32'd0);
      chk("rd_c3_rdata_hold", 32'(bus.rdata), 32'hBEEF);

      // Both ports request reads continuously: grants alternate from port 0
      step();
      issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      issue(1, 1'b0, 1'b0, 16'h0011, 16'h0000);
      k = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         @(negedge clk);
         gp = -1;
         if (bus.gnt0) gp = 0; else if (bus.gnt1) gp = 1;
         step();
         if (gp >= 0) begin
            chk($sformatf("rr_grant%0d_port", k), 32'(gp), 32'(k % 2));
            k++;
            if (k <= 2) issue(gp, 1'b0, 1'b0, 16'h0010 + 16'(gp), 16'h0000);
            else        idle(gp);
         end
      end
      chk("rr_grant_count", 32'(k), 32'd4);
      repeat (4) step();

      // Port 0 locked write burst of six while port 1 waits for a read
      issue(0, 1'b1, 1'b1, 16'h0020, 16'($urandom));
      issue(1, 1'b0, 1'b0, 16'h0010, 16'h0000);
      k = 0; n0 = 1; idle_chk = 1'b0;
      for (int c = 0; c < 80 && k < 7; c++) begin
         @(negedge clk);
         if (idle_chk) begin
            chk("burst_limit_idle", 32'(bus.busy), 32'd0);
            idle_chk = 1'b0;
         end
         gp = -1;
         if (bus.gnt0) gp = 0; else if (bus.gnt1) gp = 1;
         step();
         if (gp >= 0) begin
            chk($sformatf("burst_grant%0d_port", k), 32'(gp), 32'(order[k]));
            k++;
            if (gp == 0) begin
               if (k == 4) idle_chk = 1'b1;
               if (n0 < 6) begin
                  issue(0, 1'b1, (n0 < 5) ? 1'b1 : 1'b0, 16'h0020 + 16'(n0), 16'($urandom));
                  n0++;
               end else begin
                  idle(0);
               end
            end else begin
               idle(1);
            end
         end
      end
      chk("burst_grant_count", 32'(k), 32'd7);
      repeat (4) step();

      // Reset in the RESP cycle of a port 0 read
      issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         found = bus.gnt0;
      end
      chk("abort_read_granted", 32'(found), 32'd1);
      step();
      rst = 1'b1;
      #1;
      check_quiet("abort_async");
      issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("abort_no_rvalid0", 32'(bus.rvalid0), 32'd0);
      step();
      @(negedge clk);
      check_quiet("abort_held");
      step();
      rst = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         found = bus.gnt0;
      end
      chk("reissue_granted", 32'(found), 32'd1);
      step();
      idle(0);
      @(negedge clk);
      chk("reissue_rvalid0", 32'(bus.rvalid0), 32'd1);
      chk("reissue_rdata",   32'(bus.rdata),   32'hBEEF);
      repeat (2) step();

      // Random traffic on both ports
      act[0] = 0; act[1] = 0; forc[0] = 0; forc[1] = 0;
      for (int c = 0; c < 10300; c++) begin
         stopping = (c >= 10000);
         if (stopping && !act[0] && !act[1]) break;
         @(negedge clk);
         g[0] = bus.gnt0;
         g[1] = bus.gnt1;
         step();
         for (int p = 0; p < 2; p++) begin
            if (g[p]) act[p] = 1'b0;
            if (!act[p]) begin
               // A granted locked write commits its owner to a following beat
               if ((g[p] && forc[p]) || (!stopping && $urandom_range(0, 3) != 0)) begin
                  nwe   = 1'($urandom_range(0, 1));
                  nlock = stopping ? 1'b0 : 1'($urandom_range(0, 2) == 0);
                  issue(p, nwe, nlock, 16'($urandom_range(0, 31)), 16'($urandom));
                  act[p]  = 1'b1;
                  forc[p] = nwe & nlock;
               end else begin
                  idle(p);
                  forc[p] = 1'b0;
               end
            end
         end
      end
      chk("drain_port0_done", 32'(act[0]), 32'd0);
      chk("drain_port1_done", 32'(act[1]), 32'd0);
      idle(0);
      idle(1);
      repeat (5) step();
      chk("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
      chk("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
      chk("rsp_q_empty",  32'(rsp_q0.size() + rsp_q1.size()), 32'd0);
      chk("end_busy", 32'(bus.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, data-memory word address width.
REQ-002 Parameter DATA_W, 16, data word width.
REQ-003 Parameter MAX_BURST, 4, max consecutive beats per locked ownership (2..15).
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 reqN  in  1  (N=0 datapath LD/ST, N=1 debug/loader) access request; held with weN/addrN/wdataN stable until gntN.
REQ-007 weN  in  1  1 = write, 0 = read.
REQ-008 lockN  in  1  keep ownership for next beat (burst).
REQ-009 addrN  in  ADDR_W  word address.
REQ-010 wdataN  in  DATA_W  write data.
REQ-011 gntN  out  1  one-cycle pulse; the access is issued this cycle.
REQ-012 rvalidN  out  1  one-cycle pulse; rdata holds read result for requester N.
REQ-013 rdata  out  DATA_W  registered read data, shared.
REQ-014 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-015 mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W;  mem_rdata  in  DATA_W (synchronous memory, valid one cycle after mem_en read).
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, RESP.
REQ-018 IDLE: no req -> stay; any req -> GRANT next cycle, owner registered by arbitration.
REQ-019 Arbitration: single requester wins; both requesting -> requester other than last_owner wins (round-robin).
REQ-020 last_owner SHALL update to the owner on every IDLE->GRANT transition, not on burst beats.
REQ-021 GRANT: gnt<owner>=1, mem_en=1, mem_we/mem_addr/mem_wdata = owner's we/addr/wdata (combinational mux from current inputs); non-owner gnt=0.
REQ-022 GRANT, read -> RESP; GRANT, write -> burst check (REQ-024).
REQ-023 RESP: rdata registered from mem_rdata at end of GRANT, rvalid<owner>=1 for exactly this cycle; then burst check.
REQ-024 Burst check: owner's lock=1 and req=1 and beat_count < MAX_BURST -> GRANT same owner; else IDLE.
REQ-025 beat_count SHALL load 1 on IDLE->GRANT, increment on each burst GRANT; saturating, never wraps.
REQ-026 Latency: write = gnt 1 cycle after req sampled in IDLE; read = rvalid 2 cycles after req sampled.
REQ-027 Owner dropping req during RESP SHALL end burst (to IDLE) regardless of lock.
REQ-028 Non-owner req SHALL wait; served no later than first IDLE after current ownership ends (fairness bound MAX_BURST beats).
REQ-029 mem_en, gnt0, gnt1, rvalid0, rvalid1 SHALL never be high for both requesters simultaneously; mem_en high only in GRANT.
REQ-030 rdata SHALL hold last value outside RESP.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, last_owner=1 (req0 wins first tie), beat_count=0, rdata=0, all gnt/rvalid/mem_en/mem_we/busy=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset during GRANT or RESP SHALL abort: no rvalid issued; requester reissues after reset release.
REQ-033 First arbitration SHALL occur on first posedge clk with rst=0.

Verification
REQ-034 Reset, req0 write addr=0x0010 wdata=0xBEEF -> gnt0 at cycle 1, mem_en=mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF; busy low at cycle 2.
REQ-035 Memory preloaded 0x0010=0xBEEF; req1 read 0x0010 -> gnt1 cycle 1, rvalid1 cycle 2 with rdata=0xBEEF, rvalid0 stays 0.
REQ-036 req0 and req1 both held continuously, single-beat reads -> grants alternate 0,1,0,1 starting with 0.
REQ-037 req0 with lock0=1 held for 6 writes, req1 waiting, MAX_BURST=4 -> four consecutive gnt0, then IDLE, then gnt1 before fifth gnt0.
REQ-038 rst asserted during RESP of req0 read -> rvalid0 never pulses, all outputs 0 same cycle, normal read completes after release.
REQ-039 Random req/we/lock on both ports, 10k cycles -> no simultaneous grants, every read gnt followed by exactly one rvalid next cycle, no requester starved beyond MAX_BURST beats.
